k_address_sequencer: RTL and testbench

K_ADDRESS_SEQUENCER -- requirements
Module: k_address_sequencer

---
 rtl/k_address_sequencer_pkg.sv | 5 +
 rtl/k_address_sequencer_if.sv | 15 +
 rtl/k_address_sequencer.sv | 67 ++++++
 tb/tb_k_address_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/k_address_sequencer_pkg.sv
// k_address_sequencer_pkg: shared SHA-256 constants and sequencer state encoding
package k_address_sequencer_pkg;
    localparam int K_LENGTH_DEFAULT = 64;
    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, DRAIN, DONE} state_t;
endpackage

// File: rtl/k_address_sequencer_if.sv
// k_address_sequencer_if: run/advance handshake and constant-memory read port
interface k_address_sequencer_if
    import k_address_sequencer_pkg::*;
#(
    parameter int K_LENGTH = K_LENGTH_DEFAULT
);
    logic                        enable;
    logic                        advance;
    logic [$clog2(K_LENGTH)-1:0] k_address;
    logic                        k_read;
    logic                        address_read_complete;
    logic                        busy;
    modport master (output enable, advance, input k_address, k_read, address_read_complete, busy);
    modport slave (input enable, advance, output k_address, k_read, address_read_complete, busy);
endinterface

// File: rtl/k_address_sequencer.sv
// k_address_sequencer: walks the round-constant memory one read per advance, then waits out the read latency
module k_address_sequencer
    import k_address_sequencer_pkg::*;
#(
    parameter int K_LENGTH     = K_LENGTH_DEFAULT,
    parameter int READ_LATENCY = 2
) (
    input logic                  clock,
    input logic                  reset,
    k_address_sequencer_if.slave bus
);
    localparam int              AW         = $clog2(K_LENGTH);
    localparam logic [AW-1:0]   LAST       = AW'(K_LENGTH - 1);
    localparam logic [2:0]      DRAIN_LOAD = 3'(READ_LATENCY - 1);
    state_t        state, state_n;
    logic [AW-1:0] addr, addr_n;
    logic [2:0]    cnt, cnt_n;
    logic          k_read_q, complete_q, busy_q;
    always_comb begin
        state_n = state;
        addr_n  = addr;
        cnt_n   = cnt;
        if (!bus.enable) begin
            state_n = IDLE;
            addr_n  = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE:  state_n = ISSUE;
                ISSUE: state_n = HOLD;
                HOLD: if (bus.advance) begin
                    if (addr == LAST) begin
                        state_n = DRAIN;
                        cnt_n   = DRAIN_LOAD;
                    end else begin
                        state_n = ISSUE;
                        addr_n  = addr + 1'b1;
                    end
                end
                DRAIN: if (cnt == '0) state_n = DONE; else cnt_n = cnt - 1'b1;
                default: state_n = state;
            endcase
        end
    end
    // flags are flopped from the next state so no input reaches an output combinationally
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            k_read_q   <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            cnt        <= cnt_n;
            k_read_q   <= state_n == ISSUE;
            complete_q <= state_n == DONE;
            busy_q     <= state_n != IDLE;
        end
    end
    assign bus.k_address             = addr;
    assign bus.k_read                = k_read_q;
    assign bus.address_read_complete = complete_q;
    assign bus.busy                  = busy_q;
endmodule

// File: tb/tb_k_address_sequencer.sv
// tb_k_address_sequencer: vector table, directed corner sequences and randomized run against a cycle model
module tb_k_address_sequencer;
    localparam int K  = 64;
    localparam int RL = 2;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    bit   m_active, m_read, m_done;
    int   m_addr, m_drain;
    k_address_sequencer_if #(.K_LENGTH(K)) bus ();
    k_address_sequencer #(.K_LENGTH(K), .READ_LATENCY(RL)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clock = ~clock;
    typedef struct {
        bit r, e, a;
        bit busy, done, rd;
        int addr;
    } vec_t;
    vec_t vecs[13];
    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got busy/done/read/addr=%b/%b/%b/%0d required %b/%b/%b/%0d",
                      nm, got[8], got[7], got[6], got[5:0], exp[8], exp[7], exp[6], exp[5:0]);
    endtask
    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", nm, got, exp);
    endtask
    function automatic logic [8:0] outs();
        return {bus.busy, bus.address_read_complete, bus.k_read, bus.k_address};
    endfunction
    // a pass: one strobe per address, each waiting for an advance; after the last, RL cycles then complete
    task automatic model_step(input bit r, input bit e, input bit a);
        if (r || !e) begin
            m_active = 0; m_read = 0; m_done = 0; m_addr = 0; m_drain = 0;
        end else if (!m_active) begin
            m_active = 1; m_read = 1; m_addr = 0;
        end else if (m_read) m_read = 0;
        else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_done = 1;
        end else if (!m_done && a) begin
            if (m_addr == K - 1) m_drain = RL;
            else begin
                m_addr++;
                m_read = 1;
            end
        end
    endtask
    task automatic step(input bit r, input bit e, input bit a, input string nm);
        @(negedge clock);
        reset = r; bus.enable = e; bus.advance = a;
        @(posedge clock);
        model_step(r, e, a);
        #1;
        check(nm, outs(), {m_active, m_done, m_read, 6'(m_addr)});
    endtask
    task automatic run_to_hold(input int target);
        int t = 0;
        while (!(bus.busy && !bus.k_read && !bus.address_read_complete && int'(bus.k_address) == target) && t < 3 * K + 10) begin
            step(1'b0, 1'b1, !bus.k_read, "run_to_hold");
            t++;
        end
        check_int("run_to_hold_timeout", int'(t < 3 * K + 10), 1);
    endtask
    initial begin
        int reads, last_rd, gap_bad, t;
        bus.enable = 1'b0;
        bus.advance = 1'b0;
        vecs = '{
            '{1,0,0, 0,0,0,0}, '{0,0,0, 0,0,0,0}, '{0,0,1, 0,0,0,0},
            '{0,1,0, 1,0,1,0}, '{0,1,1, 1,0,0,0}, '{0,1,1, 1,0,1,1},
            '{0,1,0, 1,0,0,1}, '{0,1,0, 1,0,0,1}, '{0,1,1, 1,0,1,2},
            '{0,1,0, 1,0,0,2}, '{0,0,1, 0,0,0,0}, '{0,1,0, 1,0,1,0},
            '{1,1,1, 0,0,0,0}
        };
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            reset = vecs[i].r; bus.enable = vecs[i].e; bus.advance = vecs[i].a;
            @(posedge clock);
            model_step(vecs[i].r, vecs[i].e, vecs[i].a);
            #1;
            check($sformatf("vec%0d", i), outs(), {vecs[i].busy, vecs[i].done, vecs[i].rd, 6'(vecs[i].addr)});
        end
        // basic pass: advance two cycles after each strobe
        reads = 0;
        for (int i = 0; i < K; i++) begin
            t = 0;
            while (!bus.k_read && t < 8) begin
                step(1'b0, 1'b1, 1'b0, "pass_wait");
                t++;
            end
            check_int("pass_read_seen", int'(bus.k_read), 1);
            check_int("pass_addr", int'(bus.k_address), i);
            reads++;
            step(1'b0, 1'b1, 1'b0, "pass_hold");
            step(1'b0, 1'b1, 1'b1, "pass_adv");
        end
        check_int("pass_reads", reads, K);
        step(1'b0, 1'b1, 1'b0, "drain1");
        check("drain1_flag", outs(), {1'b1, 1'b0, 1'b0, 6'd63});
        step(1'b0, 1'b1, 1'b0, "drain2");
        check("done_flag", outs(), {1'b1, 1'b1, 1'b0, 6'd63});
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, i[0], "done_hold");
            check("done_hold_exp", outs(), {1'b1, 1'b1, 1'b0, 6'd63});
        end
        step(1'b0, 1'b0, 1'b0, "done_exit");
        check("done_exit_idle", outs(), 9'd0);
        // advance held high: strobes every other cycle
        reads = 0; last_rd = -2; gap_bad = 0; t = 0;
        while (!bus.address_read_complete && t < 4 * K) begin
            step(1'b0, 1'b1, 1'b1, "adv_held");
            if (bus.k_read) begin
                if (reads > 0 && t - last_rd != 2) gap_bad++;
                reads++;
                last_rd = t;
            end
            t++;
        end
        check_int("adv_held_reads", reads, K);
        check_int("adv_held_gaps", gap_bad, 0);
        check_int("adv_held_done", int'(bus.address_read_complete), 1);
        // abort in HOLD at 17, then restart from 0
        step(1'b0, 1'b0, 1'b0, "to_idle");
        step(1'b0, 1'b1, 1'b0, "abort_start");
        run_to_hold(17);
        step(1'b0, 1'b0, 1'b0, "abort");
        check("abort_idle", outs(), 9'd0);
        step(1'b0, 1'b1, 1'b0, "restart");
        check("restart_addr0", outs(), {1'b1, 1'b0, 1'b1, 6'd0});
        // abort and advance together at the last address
        run_to_hold(63);
        step(1'b0, 1'b0, 1'b1, "abort_adv");
        check("abort_adv_idle", outs(), 9'd0);
        step(1'b0, 1'b0, 1'b0, "abort_adv_after");
        check("abort_adv_no_done", outs(), 9'd0);
        // reset while draining
        step(1'b0, 1'b1, 1'b0, "rst_start");
        run_to_hold(63);
        step(1'b0, 1'b1, 1'b1, "rst_drain");
        check("in_drain", outs(), {1'b1, 1'b0, 1'b0, 6'd63});
        step(1'b1, 1'b1, 1'b0, "rst_mid");
        check("rst_mid_zero", outs(), 9'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, "post_rst");
            check_int("post_rst_no_done", int'(bus.address_read_complete), 0);
        end
        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)), "random");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
